sub_divider_ctrl: RTL

//   Multi-cycle unsigned restoring divider built around the team's ripple-borrow subtractor.
//   - The controller sequences one shared subtractor, one trial subtraction per cycle,

---
 rtl/sub_div_pkg.sv | 17 +
 rtl/borrow_sub.sv | 25 ++
 rtl/sub_divider_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sub_div_pkg.sv
// rtl/sub_div_pkg.sv - shared types and sizing helpers for the restoring divider
package sub_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 5;

  // Iteration counter width; it must hold WIDTH-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/borrow_sub.sv
// rtl/borrow_sub.sv - parameterised ripple-borrow subtractor, diff = a - b
module borrow_sub #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] brw;

  // Ripple the borrow from LSB to MSB, one full-subtractor cell per bit.
  always_comb begin
    brw    = '0;
    diff   = '0;
    brw[0] = 1'b0;
    for (int i = 0; i < W; i++) begin
      diff[i]    = a[i] ^ b[i] ^ brw[i];
      brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
    borrow_out = brw[W];
  end

endmodule

// File: rtl/sub_divider_ctrl.sv
// rtl/sub_divider_ctrl.sv - start/done sequencer for a restoring divider; optional abort via SUBDIV_ABORT_EN
module sub_divider_ctrl
  import sub_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SUBDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   trial_diff;
  logic             trial_bo;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;
  logic             abort_req;

`ifdef SUBDIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Shift in the next dividend bit; P < D keeps S within WIDTH+1 bits.
  assign trial_s = {p_q, q_q[WIDTH-1]};

  borrow_sub #(.W(WIDTH + 1)) u_sub (
    .a          (trial_s),
    .b          ({1'b0, d_q}),
    .diff       (trial_diff),
    .borrow_out (trial_bo)
  );

  // Restore on borrow, otherwise keep the difference and set the quotient bit.
  always_comb begin
    p_next = trial_bo ? trial_s[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], ~trial_bo};
  end

  // Next-state, working-register and result-register logic.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    if (state_q == RUN) begin
      if (abort_req) begin
        state_d = IDLE;
      end else begin
        p_d   = p_next;
        q_d   = q_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = q_next;
          rem_d   = p_next;
          dbz_d   = 1'b0;
        end
      end
    end else begin
      state_d = IDLE;
      if (start) begin
        p_d   = '0;
        q_d   = dividend;
        d_d   = divisor;
        cnt_d = CNT_W'(WIDTH - 1);
        if (divisor == '0) begin
          state_d = DONE;
          quot_d  = '1;
          rem_d   = dividend;
          dbz_d   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    end
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q != RUN);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
